// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program counter: pc_mode encoding and width.
package pc_pkg;

   localparam int unsigned PC_MODE_W = 3;

   typedef enum logic [PC_MODE_W-1:0] {
      PC_INC  = 3'd0,
      PC_BR   = 3'd1,
      PC_JMP  = 3'd2,
      PC_CALL = 3'd3,
      PC_RET  = 3'd4
   } pc_mode_t;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras_stack #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic [W-1:0]                   push_data,
   output logic [W-1:0]                   top,
   output logic [$clog2(DEPTH+1)-1:0]     depth
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned DEP_W = $clog2(DEPTH+1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr_inc;
   logic [PTR_W-1:0] top_ptr;

   // wr_ptr is the next free slot; when full it is also the oldest entry
   assign wr_ptr_inc = (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
   assign top_ptr    = (wr_ptr == '0) ? PTR_W'(DEPTH-1) : wr_ptr - PTR_W'(1);
   assign top        = mem[top_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         depth  <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr_inc;
         if (depth != DEP_W'(DEPTH)) depth <= depth + DEP_W'(1);
      end else if (pop && (depth != '0)) begin
         wr_ptr <= top_ptr;
         depth  <= depth - DEP_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with return-address stack for the fetch stage.
// Build macro PC_RAS_TRAP_EN redirects stack faults to TRAP_VEC and drives trap.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned PC_W      = 8,
   parameter int unsigned RAS_DEPTH = 4,
   parameter int unsigned RESET_PC  = 1,
   parameter int unsigned TRAP_VEC  = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall,
   input  logic [PC_MODE_W-1:0]             pc_mode,
   input  logic [PC_W-1:0]                  offset,
   input  logic [PC_W-1:0]                  target,
   output logic [PC_W-1:0]                  pc,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_depth,
   output logic                             ras_empty,
   output logic                             ras_full,
   output logic                             ras_ovf,
   output logic                             ras_unf,
   output logic                             trap
);

   localparam int unsigned DEP_W = $clog2(RAS_DEPTH+1);
`ifdef PC_RAS_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic [PC_W-1:0] next_pc;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] ras_top;
   logic [PC_W-1:0] trap_pc;
   logic            push;
   logic            pop;
   logic            ovf_c;
   logic            unf_c;

   assign pc_inc    = pc + PC_W'(1);
   assign trap_pc   = PC_W'(TRAP_VEC);
   assign ras_empty = (ras_depth == '0);
   assign ras_full  = (ras_depth == DEP_W'(RAS_DEPTH));

   ras_stack #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top       (ras_top),
      .depth     (ras_depth)
   );

   // Next-pc selection and stack control; nothing moves while stalled
   always_comb begin
      next_pc = pc_inc;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_c   = 1'b0;
      unf_c   = 1'b0;
      if (!stall) begin
         case (pc_mode)
            PC_BR:   next_pc = pc_inc + offset;
            PC_JMP:  next_pc = target;
            PC_CALL: begin
               next_pc = target;
               if (ras_full) begin
                  ovf_c = 1'b1;
                  if (TRAP_EN) next_pc = trap_pc;
                  else         push    = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end
            PC_RET: begin
               if (ras_empty) begin
                  unf_c = 1'b1;
                  if (TRAP_EN) next_pc = trap_pc;
               end else begin
                  next_pc = ras_top;
                  pop     = 1'b1;
               end
            end
            default: next_pc = pc_inc;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= PC_W'(RESET_PC);
         ras_ovf <= 1'b0;
         ras_unf <= 1'b0;
      end else begin
         if (!stall) pc <= next_pc;
         ras_ovf <= ovf_c;
         ras_unf <= unf_c;
      end
   end

`ifdef PC_RAS_TRAP_EN
   logic trap_c;
   assign trap_c = ovf_c | unf_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) trap <= 1'b0;
      else     trap <= trap_c;
   end
`else
   assign trap = 1'b0;
`endif

endmodule
